// File: rtl/conv_window_gen.sv
// conv_window_gen: sliding 5x5 window generator for a single convolution PE.
// Takes a raster-order pixel stream and keeps the previous 4 rows in a line
// buffer. For every stride-1 position whose full 5x5 window lies inside the
// frame, it presents all 25 taps through a one-entry output register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and its data stable until that edge.
// A consumer may assert or drop ready at any time. in_ready depends
// combinationally on win_ready and on registered state only.
module conv_window_gen #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     in_pix,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [25*DATA_W-1:0]  win_taps,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic [1:0]            dbg_state
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]          state;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;

    // lb[0] holds row r-4 and lb[3] holds row r-1 at each column.
    logic [DATA_W-1:0]   lb      [4][IMG_W];
    logic [DATA_W-1:0]   win     [5][5];
    logic [DATA_W-1:0]   win_nxt [5][5];
    logic [25*DATA_W-1:0] taps_nxt;

    logic accept;
    logic emit;
    logic last_col;
    logic last_row;

    assign accept   = in_valid && in_ready;
    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));
    // Only positions whose window sits fully inside the frame. c>=4 also
    // rules out windows that would straddle a row wrap.
    assign emit     = (row >= RW'(4)) && (col >= CW'(4));

    assign in_ready   = (state == S_STREAM) && (!win_valid || win_ready);
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DRAIN) && (!win_valid || win_ready);
    assign dbg_state  = state;

    // Next window: shift one column left, new right column from the line buffer plus in_pix.
    always_comb begin
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
            win_nxt[r][4] = (r < 4) ? lb[r][col] : in_pix;
        end
    end

    // Flatten the next window into tap order k = r*5 + c.
    always_comb begin
        taps_nxt = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                taps_nxt[DATA_W*(r*5+c) +: DATA_W] = win_nxt[r][c];
            end
        end
    end

    // Line buffer column update on accept; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][col] <= lb[1][col];
            lb[1][col] <= lb[2][col];
            lb[2][col] <= lb[3][col];
            lb[3][col] <= in_pix;
        end
    end

    // 5x5 shift register advances only on an accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win[r][c] <= win_nxt[r][c];
                end
            end
        end
    end

    // Output register: load on emitting accept, otherwise clear on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_taps  <= '0;
        end else if (accept && emit) begin
            win_valid <= 1'b1;
            win_taps  <= taps_nxt;
        end else if (win_valid && win_ready) begin
            win_valid <= 1'b0;
        end
    end

    // Frame FSM and raster counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_STREAM;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                row   <= '0;
                                state <= S_DRAIN;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!win_valid || win_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Testbench for conv_window_gen: a default 32x32 instance and a small 8x6 one.
module tb_conv_window_gen;

    localparam int W  = 32;
    localparam int H  = 32;
    localparam int SW = 8;
    localparam int SH = 6;
    localparam int NWIN = (W - 4) * (H - 4);

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // large instance signals
    logic         start, in_valid, in_ready, win_valid, win_ready, busy, frame_done;
    logic [7:0]   in_pix;
    logic [199:0] win_taps;
    logic [1:0]   dbg_state;

    // small instance signals
    logic         s_start, s_in_valid, s_in_ready, s_win_valid, s_win_ready, s_busy, s_frame_done;
    logic [7:0]   s_in_pix;
    logic [199:0] s_win_taps;
    logic [1:0]   s_dbg_state;

    int checks = 0;
    int errors = 0;

    conv_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_pix(in_pix), .in_valid(in_valid),
        .in_ready(in_ready), .win_taps(win_taps), .win_valid(win_valid),
        .win_ready(win_ready), .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
    );

    conv_window_gen #(.IMG_W(SW), .IMG_H(SH), .DATA_W(8)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .in_pix(s_in_pix), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .win_taps(s_win_taps), .win_valid(s_win_valid),
        .win_ready(s_win_ready), .busy(s_busy), .frame_done(s_frame_done), .dbg_state(s_dbg_state)
    );

    // Expected tap k of window n for the 32x32 ramp frame pix = (r*32+c) & 0xFF.
    function automatic logic [7:0] ramp_tap(input int n, input int k);
        int wr, wc;
        wr = 4 + n / (W - 4);
        wc = 4 + n % (W - 4);
        return 8'(((wr - 4 + k / 5) * W + (wc - 4 + k % 5)) & 255);
    endfunction

    // Drive one full ramp frame into the large instance and check every window.
    task automatic run_ramp(input string name, input int stall_win, input bit gaps,
                            input bit pulse_start);
        int r, c, n, cyc, stall_cnt, fd_cnt, acc_cyc, first_cyc;
        bit done, bad, stall;
        logic [199:0] held;
        r = 0; c = 0; n = 0; cyc = 0; stall_cnt = 0; fd_cnt = 0;
        acc_cyc = -1; first_cyc = -1; done = 0; held = '0;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; win_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || dbg_state !== 2'd1)
            begin errors++; $display("FAIL %s start busy=%b state=%0d exp busy=1 state=1", name, busy, dbg_state); end
        while (!done && cyc < 20000) begin
            stall     = (win_valid === 1'b1) && (n == stall_win) && (stall_cnt < 3);
            win_ready = !stall;
            in_valid  = (r < H) && (!gaps || $urandom_range(0, 1) == 1);
            in_pix    = 8'((r * W + c) & 255);
            start     = pulse_start && ((cyc % 7 == 3) || r == H);
            #1;
            if (stall) begin
                if (stall_cnt == 0) held = win_taps;
                else begin
                    checks++;
                    if (win_valid !== 1'b1 || win_taps !== held)
                        begin errors++; $display("FAIL %s stall hold valid=%b taps=%h exp valid=1 taps=%h", name, win_valid, win_taps, held); end
                end
                checks++;
                if (in_ready !== 1'b0)
                    begin errors++; $display("FAIL %s stall in_ready=%b exp 0", name, in_ready); end
                stall_cnt++;
            end
            if (win_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
            if (win_valid === 1'b1 && win_ready) begin
                bad = 0;
                for (int k = 0; k < 25; k++)
                    if (win_taps[8*k +: 8] !== ramp_tap(n, k)) bad = 1;
                checks++;
                if (bad || n >= NWIN)
                    begin errors++; $display("FAIL %s window %0d taps=%h (tap0 exp %h tap24 exp %h)", name, n, win_taps, ramp_tap(n, 0), ramp_tap(n, 24)); end
                n++;
            end
            if (frame_done === 1'b1) begin fd_cnt++; done = 1; end
            if (in_valid && in_ready === 1'b1) begin
                if (r == 4 && c == 4) acc_cyc = cyc;
                c++;
                if (c == W) begin c = 0; r++; end
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; win_ready = 1'b1;
        #1;
        checks++;
        if (!done) begin errors++; $display("FAIL %s timeout windows=%0d exp %0d", name, n, NWIN); end
        checks++;
        if (n != NWIN) begin errors++; $display("FAIL %s window count got %0d exp %0d", name, n, NWIN); end
        checks++;
        if (fd_cnt != 1 || frame_done !== 1'b0)
            begin errors++; $display("FAIL %s frame_done pulses=%0d now=%b exp 1 pulse", name, fd_cnt, frame_done); end
        checks++;
        if (first_cyc - acc_cyc != 1)
            begin errors++; $display("FAIL %s first window latency got %0d exp 1", name, first_cyc - acc_cyc); end
        checks++;
        if (busy !== 1'b0 || win_valid !== 1'b0)
            begin errors++; $display("FAIL %s end busy=%b win_valid=%b exp 0 0", name, busy, win_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; s_start = 1'b1;
        in_valid = 1'b0; win_ready = 1'b0; in_pix = '0;
        s_in_valid = 1'b0; s_win_ready = 1'b1; s_in_pix = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || win_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0)
            begin errors++; $display("FAIL reset ctrl in_ready=%b win_valid=%b busy=%b frame_done=%b exp 0000", in_ready, win_valid, busy, frame_done); end
        checks++;
        if (win_taps !== '0 || dbg_state !== 2'd0)
            begin errors++; $display("FAIL reset taps=%h state=%0d exp 0 0", win_taps, dbg_state); end
        checks++;
        if (s_busy !== 1'b0 || s_win_valid !== 1'b0 || s_in_ready !== 1'b0 || s_win_taps !== '0)
            begin errors++; $display("FAIL reset small busy=%b win_valid=%b in_ready=%b exp 000", s_busy, s_win_valid, s_in_ready); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; s_start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset start_ignored busy=%b exp 0", busy); end
    endtask

    task automatic test_ramp();
        run_ramp("ramp", -1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_ramp("back_to_back", -1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        run_ramp("stall", 10, 1'b0, 1'b0);
    endtask

    task automatic test_gaps();
        run_ramp("gaps", -1, 1'b1, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_ramp("start_ignored", -1, 1'b0, 1'b1);
    endtask

    task automatic test_mid_reset();
        int acc, cyc;
        acc = 0; cyc = 0;
        @(negedge clk);
        start = 1'b1; win_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (acc < 500 && cyc < 2000) begin
            in_valid = 1'b1;
            in_pix   = 8'(acc & 255);
            #1;
            if (in_ready === 1'b1) acc++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (acc != 500) begin errors++; $display("FAIL mid_reset accepted %0d exp 500", acc); end
        checks++;
        if (win_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || win_taps !== '0 || dbg_state !== 2'd0)
            begin errors++; $display("FAIL mid_reset win_valid=%b busy=%b in_ready=%b state=%0d exp all 0", win_valid, busy, in_ready, dbg_state); end
        run_ramp("after_reset", -1, 1'b0, 1'b0);
    endtask

    task automatic test_small();
        int r, c, n, cyc, fd_cnt, wr, wc;
        bit done;
        r = 0; c = 0; n = 0; cyc = 0; fd_cnt = 0; done = 0;
        @(negedge clk);
        s_start = 1'b1; s_win_ready = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        while (!done && cyc < 1000) begin
            s_in_valid = (r < SH);
            s_in_pix   = 8'(r * SW + c);
            #1;
            if (s_win_valid === 1'b1) begin
                wr = 4 + n / (SW - 4);
                wc = 4 + n % (SW - 4);
                checks++;
                if (s_win_taps[8*24 +: 8] !== 8'(wr * SW + wc) || s_win_taps[7:0] !== 8'((wr - 4) * SW + wc - 4) || n >= 8)
                    begin errors++; $display("FAIL small window %0d tap24=%0d tap0=%0d exp %0d %0d", n, s_win_taps[8*24 +: 8], s_win_taps[7:0], wr * SW + wc, (wr - 4) * SW + wc - 4); end
                n++;
            end
            if (s_frame_done === 1'b1) begin fd_cnt++; done = 1; end
            if (s_in_valid && s_in_ready === 1'b1) begin
                c++;
                if (c == SW) begin c = 0; r++; end
            end
            cyc++;
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        #1;
        checks++;
        if (n != 8 || fd_cnt != 1)
            begin errors++; $display("FAIL small count windows=%0d done=%0d exp 8 1", n, fd_cnt); end
        checks++;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL small end busy=%b exp 0", s_busy); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_stall();
        test_gaps();
        test_mid_reset();
        test_small();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
